ack_queue_rr: RTL and testbench

- Parametrised successor to the two-app cumulative-ACK sender. Serves NUM_APPS libnet instances.
- Sends one single-beat ACK frame per app, only when that app's expected sequence number has changed or a keepalive interval expires.
- Apps are served by fair round-robin, with a full AXI-S handshake: tvalid/tdata are held stable until tready.
- Sits between the libnet instances and the sysnet TX arbiter.

---
 rtl/ack_pkg.sv | 49 ++++
 rtl/ack_queue_rr_rr_pick.sv | 30 +++
 rtl/ack_queue_rr.sv | 166 ++++++++++++++++
 tb/tb_ack_queue_rr.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ack_pkg.sv
// Shared constants, frame field offsets and frame builder for the round-robin ACK sender.
package ack_pkg;

    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned APPID_W = 8;
    localparam int unsigned TDATA_W = 512;

    localparam int unsigned MAC_DEST_LSB = 0;
    localparam int unsigned MAC_SRC_LSB  = 48;
    localparam int unsigned ETHTYPE_LSB  = 96;
    localparam int unsigned IP_HDR_LSB   = 112;
    localparam int unsigned UDP_HDR_LSB  = 272;
    localparam int unsigned APPID_LSB    = 336;
    localparam int unsigned SEQ_LSB      = 344;
    localparam int unsigned ACK_BIT      = 376;
    localparam int unsigned SYN_BIT      = 377;

    localparam logic ACK_VAL = 1'b1;
    localparam logic SYN_VAL = 1'b0;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    function automatic logic [TDATA_W-1:0] build_frame(
        input logic [47:0]        mac_dest,
        input logic [47:0]        mac_src,
        input logic [15:0]        ethtype,
        input logic [159:0]       ip_hdr,
        input logic [63:0]        udp_hdr,
        input logic [APPID_W-1:0] app_id,
        input logic [SEQ_W-1:0]   seq
    );
        logic [TDATA_W-1:0] f;
        f = '0;
        f[MAC_DEST_LSB +: 48]    = mac_dest;
        f[MAC_SRC_LSB  +: 48]    = mac_src;
        f[ETHTYPE_LSB  +: 16]    = ethtype;
        f[IP_HDR_LSB   +: 160]   = ip_hdr;
        f[UDP_HDR_LSB  +: 64]    = udp_hdr;
        f[APPID_LSB +: APPID_W]  = app_id;
        f[SEQ_LSB   +: SEQ_W]    = seq;
        f[ACK_BIT]               = ACK_VAL;
        f[SYN_BIT]               = SYN_VAL;
        return f;
    endfunction

endpackage

// File: rtl/ack_queue_rr_rr_pick.sv
// Round-robin priority select: first set pending bit at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     i_pending,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_any,
    output logic [PTR_W-1:0] o_sel
);

    int unsigned w_idx;

    always_comb begin
        o_any = 1'b0;
        o_sel = '0;
        w_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = 32'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_any && i_pending[w_idx[PTR_W-1:0]]) begin
                o_any = 1'b1;
                o_sel = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ack_queue_rr.sv
// Cumulative-ACK sender for NUM_APPS libnet instances: per-app shadow seq, round-robin
// selection, keepalive re-flagging and a held AXI-S single-beat frame.
module ack_queue_rr
    import ack_pkg::*;
#(
    parameter int unsigned   NUM_APPS         = 4,
    parameter logic [7:0]    APP_ID_BASE      = 8'h00,
    parameter int unsigned   KEEPALIVE_CYCLES = 1024,
    parameter logic [47:0]   MAC_DEST         = 48'hA1B1C1D1E1F1,
    parameter logic [47:0]   MAC_SRC          = 48'h121212121212,
    parameter logic [15:0]   ETHTYPE          = 16'h0800,
    parameter logic [159:0]  IP_HDR           = {5{32'hAAAAAAAA}},
    parameter logic [63:0]   UDP_HDR          = 64'hBBBBBBBBBBBBBBBB,
    parameter logic [63:0]   TUSER_VAL        = 64'hFFFFFFFFFFFFFFFF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [SEQ_W*NUM_APPS-1:0] seq_in,
    input  logic [NUM_APPS-1:0]       seq_valid,
    output logic [TDATA_W-1:0]        tx_tdata,
    output logic [63:0]               tx_tkeep,
    output logic                      tx_tvalid,
    output logic [63:0]               tx_tuser,
    output logic                      tx_tlast,
    input  logic                      tx_tready,
    output logic [31:0]               frames_sent
);

    localparam int unsigned PTR_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;

    logic                 r_rst_meta;
    logic                 r_rst_n;
    state_t               r_state;
    logic [SEQ_W-1:0]     r_seq [NUM_APPS];
    logic [NUM_APPS-1:0]  r_pending;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_sel;
    logic [31:0]          r_ka;
    logic [31:0]          r_frames_sent;
    logic [TDATA_W-1:0]   r_tdata;
    logic [63:0]          r_tkeep;
    logic [63:0]          r_tuser;
    logic                 r_tvalid;
    logic                 r_tlast;

    logic                 w_any;
    logic [PTR_W-1:0]     w_sel;
    logic                 w_latch;
    logic                 w_hs;
    logic                 w_ka_fire;
    logic [NUM_APPS-1:0]  w_pending_nxt;
    logic [APPID_W-1:0]   w_app_id;
    logic [TDATA_W-1:0]   w_frame;

    // Assertion is immediate; release is retimed so every register leaves reset on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    rr_pick #(
        .N     (NUM_APPS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_any     (w_any),
        .o_sel     (w_sel)
    );

    assign w_latch   = (r_state == ST_IDLE) && w_any;
    assign w_hs      = (r_state == ST_SEND) && tx_tready;
    assign w_ka_fire = (KEEPALIVE_CYCLES != 0) && (r_ka == 32'(KEEPALIVE_CYCLES - 1));
    assign w_app_id  = APP_ID_BASE + APPID_W'(w_sel);
    assign w_frame   = build_frame(MAC_DEST, MAC_SRC, ETHTYPE, IP_HDR, UDP_HDR,
                                   w_app_id, r_seq[w_sel]);

    // Set sources are applied after the latch clear so a same-cycle update re-arms the app.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_latch) begin
            w_pending_nxt[w_sel] = 1'b0;
        end
        if (w_ka_fire) begin
            w_pending_nxt = '1;
        end
        w_pending_nxt = w_pending_nxt | seq_valid;
    end

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_pending <= '0;
            for (int unsigned i = 0; i < NUM_APPS; i++) begin
                r_seq[i] <= '0;
            end
        end else begin
            r_pending <= w_pending_nxt;
            for (int unsigned i = 0; i < NUM_APPS; i++) begin
                if (seq_valid[i]) begin
                    r_seq[i] <= seq_in[SEQ_W*i +: SEQ_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_ka <= '0;
        end else if (w_hs || w_ka_fire) begin
            r_ka <= '0;
        end else if (KEEPALIVE_CYCLES != 0) begin
            r_ka <= r_ka + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state       <= ST_IDLE;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tuser       <= '0;
            r_sel         <= '0;
            r_ptr         <= '0;
            r_frames_sent <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_tdata  <= w_frame;
                        r_tkeep  <= '1;
                        r_tuser  <= TUSER_VAL;
                        r_tlast  <= 1'b1;
                        r_tvalid <= 1'b1;
                        r_sel    <= w_sel;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_tready) begin
                        r_tvalid      <= 1'b0;
                        r_tlast       <= 1'b0;
                        r_ptr         <= (r_sel == PTR_W'(NUM_APPS - 1)) ? '0 : r_sel + 1'b1;
                        r_frames_sent <= r_frames_sent + 32'd1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_tdata    = r_tdata;
    assign tx_tkeep    = r_tkeep;
    assign tx_tvalid   = r_tvalid;
    assign tx_tuser    = r_tuser;
    assign tx_tlast    = r_tlast;
    assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_ack_queue_rr.sv
// Directed bench for ack_queue_rr: scoreboard of expected frames plus a keepalive-only instance.
module tb_ack_queue_rr;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] seq_in;
    logic [3:0]   seq_valid;
    logic         tready;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic [63:0]  tuser;
    logic         tvalid;
    logic         tlast;
    logic [31:0]  fsent;

    logic [127:0] ka_seq_in    = '0;
    logic [3:0]   ka_seq_valid = '0;
    logic         ka_tready    = 1'b1;
    logic [511:0] ka_tdata;
    logic [63:0]  ka_tkeep;
    logic [63:0]  ka_tuser;
    logic         ka_tvalid;
    logic         ka_tlast;
    logic [31:0]  ka_fsent;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] seq;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned hs_log[$];

    int unsigned ka_idx      = 0;
    int unsigned ka_last     = 0;
    bit          ka_have     = 1'b0;
    int unsigned ka_frames   = 0;
    int unsigned ka_since    = 0;

    ack_queue_rr #(
        .NUM_APPS         (4),
        .APP_ID_BASE      (8'h00),
        .KEEPALIVE_CYCLES (0)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .seq_in      (seq_in),
        .seq_valid   (seq_valid),
        .tx_tdata    (tdata),
        .tx_tkeep    (tkeep),
        .tx_tvalid   (tvalid),
        .tx_tuser    (tuser),
        .tx_tlast    (tlast),
        .tx_tready   (tready),
        .frames_sent (fsent)
    );

    ack_queue_rr #(
        .NUM_APPS         (4),
        .APP_ID_BASE      (8'hFE),
        .KEEPALIVE_CYCLES (16)
    ) dut_ka (
        .clk         (clk),
        .resetn      (resetn),
        .seq_in      (ka_seq_in),
        .seq_valid   (ka_seq_valid),
        .tx_tdata    (ka_tdata),
        .tx_tkeep    (ka_tkeep),
        .tx_tvalid   (ka_tvalid),
        .tx_tuser    (ka_tuser),
        .tx_tlast    (ka_tlast),
        .tx_tready   (ka_tready),
        .frames_sent (ka_fsent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] exp_frame(input logic [7:0] id, input logic [31:0] seq);
        return {134'd0, 1'b0, 1'b1, seq, id, 64'hBBBBBBBBBBBBBBBB, {5{32'hAAAAAAAA}},
                16'h0800, 48'h121212121212, 48'hA1B1C1D1E1F1};
    endfunction

    // Handshake monitor for the main instance: every accepted frame must match the scoreboard head.
    always @(negedge clk) begin
        if (resetn && tvalid && tready) begin
            hs_log.push_back(cyc);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_frame got id=%0h seq=%0h expected no frame", tdata[343:336], tdata[375:344]);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert (tdata === exp_frame(mon_e.id, mon_e.seq)) else begin
                    errors++;
                    $error("FAIL frame_data got id=%0h seq=%0h ack=%0b expected id=%0h seq=%0h ack=1",
                           tdata[343:336], tdata[375:344], tdata[376], mon_e.id, mon_e.seq);
                end
                checks++;
                assert ({tlast, tkeep, tuser} === {1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}) else begin
                    errors++;
                    $error("FAIL frame_side got tlast=%0b tkeep=%0h tuser=%0h expected 1/all-ones/all-ones",
                           tlast, tkeep, tuser);
                end
            end
        end
    end

    // Keepalive instance: seq 0 frames in wrapped-id round-robin order, 2 cycles apart, 18 between rounds.
    always @(negedge clk) begin
        if (!resetn) begin
            ka_idx   = 0;
            ka_have  = 1'b0;
            ka_since = 0;
        end else if (ka_tvalid) begin
            checks++;
            assert (ka_tdata === exp_frame(8'(8'hFE + ka_idx), 32'd0) && ka_tlast === 1'b1 &&
                    ka_tkeep === '1 && ka_tuser === '1) else begin
                errors++;
                $error("FAIL ka_frame got id=%0h seq=%0h expected id=%0h seq=0",
                       ka_tdata[343:336], ka_tdata[375:344], 8'(8'hFE + ka_idx));
            end
            if (ka_have) begin
                checks++;
                assert ((cyc - ka_last) === ((ka_idx == 0) ? 18 : 2)) else begin
                    errors++;
                    $error("FAIL ka_gap got %0d expected %0d", cyc - ka_last, (ka_idx == 0) ? 18 : 2);
                end
            end
            ka_last   = cyc;
            ka_have   = 1'b1;
            ka_idx    = (ka_idx + 1) % 4;
            ka_frames++;
            ka_since++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_drain(input int unsigned max_cyc, input string tag);
        int unsigned n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout got %0d outstanding expected 0", tag, sb.size());
        end
    endtask

    task automatic wait_valid(input int unsigned max_cyc, input string tag);
        int unsigned n = 0;
        @(negedge clk);
        while (!tvalid && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check32(tag, 32'(tvalid), 32'd1);
    endtask

    task automatic quiet(input int unsigned n, input string tag);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tvalid) seen = 1'b1;
        end
        check32(tag, 32'(seen), 32'd0);
        tick();
    endtask

    task automatic strobe(input int unsigned app, input logic [31:0] val);
        seq_in[32*app +: 32] = val;
        seq_valid            = 4'(1 << app);
    endtask

    initial begin
        logic [511:0] held;
        bit           stable;
        exp_t         e;

        resetn    = 1'b0;
        seq_in    = '0;
        seq_valid = '0;
        tready    = 1'b1;
        repeat (3) tick();
        check32("rst_tvalid", 32'(tvalid), 32'd0);
        check32("rst_tlast", 32'(tlast), 32'd0);
        check32("rst_tdata_or", 32'(|tdata), 32'd0);
        check32("rst_tkeep_or", 32'(|tkeep), 32'd0);
        check32("rst_tuser_or", 32'(|tuser), 32'd0);
        check32("rst_frames", fsent, 32'd0);
        resetn = 1'b1;
        repeat (3) tick();

        quiet(200, "idle_no_tvalid");
        check32("idle_frames", fsent, 32'd0);

        // All four apps at once, pointer at 0.
        seq_in    = {32'd40, 32'd30, 32'd20, 32'd10};
        seq_valid = 4'hF;
        for (int unsigned i = 0; i < 4; i++) begin
            e.id = 8'(i); e.seq = 32'(10 * (i + 1)); sb.push_back(e);
        end
        hs_log.delete();
        tick();
        seq_valid = '0;
        wait_drain(40, "four_apps");
        check32("four_frames", fsent, 32'd4);
        check32("four_spacing", (hs_log.size() == 4) ? (hs_log[3] - hs_log[0]) : 32'd0, 32'd6);

        // Single update on app 2: tvalid two edges after the strobe is sampled.
        strobe(2, 32'h0000_1234);
        e.id = 8'h02; e.seq = 32'h1234; sb.push_back(e);
        tick();
        seq_valid = '0;
        @(negedge clk);
        check32("lat_n1_tvalid", 32'(tvalid), 32'd0);
        @(negedge clk);
        check32("lat_n2_tvalid", 32'(tvalid), 32'd1);
        wait_drain(20, "single");
        check32("single_frames", fsent, 32'd5);
        quiet(20, "single_no_more");

        // Update on the latch cycle: old value goes out, new value follows.
        strobe(0, 32'h0000_00A0);
        e.id = 8'h00; e.seq = 32'hA0; sb.push_back(e);
        tick();
        strobe(0, 32'h0000_00B0);
        e.id = 8'h00; e.seq = 32'hB0; sb.push_back(e);
        tick();
        seq_valid = '0;
        wait_drain(20, "same_cycle");
        check32("same_cycle_frames", fsent, 32'd7);

        // Backpressure: frame held 50 cycles while app1 and app3 are updated.
        tready = 1'b0;
        strobe(1, 32'h0000_0055);
        e.id = 8'h01; e.seq = 32'h55; sb.push_back(e);
        tick();
        seq_valid = '0;
        wait_valid(10, "bp_tvalid_up");
        held   = tdata;
        stable = 1'b1;
        for (int unsigned i = 0; i < 50; i++) begin
            tick();
            if (i == 5)       strobe(1, 32'h0000_0099);
            else if (i == 10) strobe(3, 32'h0000_0300);
            else if (i == 11) strobe(3, 32'h0000_0301);
            else              seq_valid = '0;
            @(negedge clk);
            if (!tvalid || tdata !== held) stable = 1'b0;
        end
        check32("bp_stable", 32'(stable), 32'd1);
        e.id = 8'h03; e.seq = 32'h301; sb.push_back(e);
        e.id = 8'h01; e.seq = 32'h99;  sb.push_back(e);
        tick();
        seq_valid = '0;
        tready    = 1'b1;
        wait_drain(30, "backpressure");
        check32("bp_frames", fsent, 32'd10);

        // Reset during SEND drops the frame and all pending state.
        tready = 1'b0;
        strobe(0, 32'h0000_0066);
        tick();
        seq_valid = '0;
        wait_valid(10, "rst_send_tvalid_up");
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check32("rst_async_tvalid", 32'(tvalid), 32'd0);
        check32("rst_async_frames", fsent, 32'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tready = 1'b1;
        quiet(50, "post_rst_quiet");
        check32("post_rst_frames", fsent, 32'd0);
        strobe(1, 32'h0000_0077);
        e.id = 8'h01; e.seq = 32'h77; sb.push_back(e);
        tick();
        seq_valid = '0;
        wait_drain(20, "post_rst");
        check32("post_rst_frames_1", fsent, 32'd1);

        repeat (60) tick();
        check32("ka_frames_sent", ka_fsent, 32'(ka_since));
        checks++;
        assert (ka_frames >= 16) else begin
            errors++;
            $error("FAIL ka_count got %0d expected at least 16", ka_frames);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
